// File: rtl/adder_share_pkg.sv
// Shared types and constants for the byte-serial shared adder sequencer.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_WORDS = 4;
  localparam int ID_W          = 1;

  // Signed overflow of the top byte: carry into its MSB xor the carry out of it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic cout);
    return (a_msb ^ b_msb ^ s_msb) ^ cout;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_add8_slice.sv
// Purely combinational 8-bit ripple-carry adder slice shared by both requesters.
module add8_slice
  import adder_share_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic carry_s;

  // Ripple the carry through the eight bit positions.
  always_comb begin
    s       = {BYTE_W{1'b0}};
    carry_s = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i]    = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    cout = carry_s;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer time-sharing one 8-bit slice for two W-bit add requests.
// Optional signed-overflow output rsp_ovf is enabled by defining ADDER_SHARE_OVF_EN.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*WORDS-1:0]    req0_a,
  input  logic [8*WORDS-1:0]    req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*WORDS-1:0]    req1_a,
  input  logic [8*WORDS-1:0]    req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*WORDS-1:0]    rsp_sum,
  output logic                  rsp_cout,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  localparam int W     = BYTE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t              state_r;
  logic                ptr_r;
  logic [IDX_W-1:0]    idx_r;
  logic                carry_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                cout_r;
  logic [ID_W-1:0]     id_r;
  logic                valid_r;
  logic                busy_r;
`ifdef ADDER_SHARE_OVF_EN
  logic                ovf_r;
`endif

  logic                grant_s;
  logic                grant_vld_s;
  logic                last_s;
  logic [IDX_W+2:0]    byte_off_s;
  logic [BYTE_W-1:0]   a_byte_s;
  logic [BYTE_W-1:0]   b_byte_s;
  logic [BYTE_W-1:0]   s_byte_s;
  logic                cout_byte_s;

  // Round-robin grant: a tie goes to the requester not granted last.
  always_comb begin
    grant_s     = 1'b0;
    grant_vld_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s     = ~ptr_r;
      grant_vld_s = 1'b1;
    end else if (req1_valid) begin
      grant_s     = 1'b1;
      grant_vld_s = 1'b1;
    end else if (req0_valid) begin
      grant_s     = 1'b0;
      grant_vld_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      grant_vld_s = 1'b0;
    end
  end

  assign req0_ready = (state_r == IDLE) && grant_vld_s && !grant_s;
  assign req1_ready = (state_r == IDLE) && grant_vld_s &&  grant_s;

  assign byte_off_s = {idx_r, 3'b000};
  assign a_byte_s   = a_r[byte_off_s +: BYTE_W];
  assign b_byte_s   = b_r[byte_off_s +: BYTE_W];
  assign last_s     = (idx_r == IDX_W'(WORDS - 1));

  add8_slice u_slice (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .s    (s_byte_s),
    .cout (cout_byte_s)
  );

  // Sequencer FSM with the operand, carry, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 1'b1;
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      id_r    <= {ID_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            a_r     <= grant_s ? req1_a : req0_a;
            b_r     <= grant_s ? req1_b : req0_b;
            carry_r <= grant_s ? req1_cin : req0_cin;
            id_r    <= grant_s;
            ptr_r   <= grant_s;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD: begin
          sum_r[byte_off_s +: BYTE_W] <= s_byte_s;
          carry_r <= cout_byte_s;
          if (last_s) begin
            cout_r  <= cout_byte_s;
            valid_r <= 1'b1;
            idx_r   <= {IDX_W{1'b0}};
            state_r <= DONE;
`ifdef ADDER_SHARE_OVF_EN
            ovf_r   <= signed_ovf(a_byte_s[BYTE_W-1], b_byte_s[BYTE_W-1],
                                  s_byte_s[BYTE_W-1], cout_byte_s);
`endif
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = valid_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_id    = id_r;
  assign busy      = busy_r;
`ifdef ADDER_SHARE_OVF_EN
  assign rsp_ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed self-checking bench for adder_share_ctrl (WORDS=4 and WORDS=1 instances).
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, busy;
  logic [31:0] rsp_sum;
  logic [0:0]  rsp_id;

  logic        w1_req0_valid, w1_req0_ready, w1_req1_ready;
  logic [7:0]  w1_req0_a, w1_req0_b;
  logic        w1_rsp_valid, w1_rsp_cout, w1_busy;
  logic [7:0]  w1_rsp_sum;
  logic [0:0]  w1_rsp_id;
`ifdef ADDER_SHARE_OVF_EN
  logic        rsp_ovf, w1_rsp_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  adder_share_ctrl #(.WORDS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
`ifdef ADDER_SHARE_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  adder_share_ctrl #(.WORDS(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_a(w1_req0_a), .req0_b(w1_req0_b), .req0_cin(1'b0),
    .req1_valid(1'b0), .req1_ready(w1_req1_ready), .req1_a(8'h00), .req1_b(8'h00), .req1_cin(1'b0),
    .rsp_valid(w1_rsp_valid), .rsp_ready(1'b1), .rsp_sum(w1_rsp_sum), .rsp_cout(w1_rsp_cout),
    .rsp_id(w1_rsp_id), .busy(w1_busy)
`ifdef ADDER_SHARE_OVF_EN
    , .rsp_ovf(w1_rsp_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the selected instance raises rsp_valid, bounded by max_cyc.
  task automatic wait_rsp(input bit sel_w1, input int max_cyc, output int n);
    n = 0;
    while (((sel_w1 ? w1_rsp_valid : rsp_valid) !== 1'b1) && (n < max_cyc)) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    w1_req0_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; req0_cin = 1'b0; req1_cin = 1'b0;
    req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
    rsp_ready = 1'b0;
    w1_req0_valid = 1'b0; w1_req0_a = 8'h00; w1_req0_b = 8'h00;
    #2;
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sum", rsp_sum, 32'h0);
    check_eq("rst_ready0", req0_ready, 1'b0);
    do_reset();

    // Carry ripple through all four bytes.
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    check_eq("cr_ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    check_eq("cr_busy", busy, 1'b1);
    wait_rsp(1'b0, 20, cyc);
    check_eq("cr_latency", cyc, 4);
    check_eq("cr_sum", rsp_sum, 32'h0000_0000);
    check_eq("cr_cout", rsp_cout, 1'b1);
    check_eq("cr_id", rsp_id, 1'b0);
    rsp_ready = 1'b1;
    tick();
    check_eq("cr_idle_busy", busy, 1'b0);
    check_eq("cr_idle_valid", rsp_valid, 1'b0);

    // Round-robin with both requesters continuously valid.
    do_reset();
    req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0;
    req1_a = 32'h8000_0000; req1_b = 32'h8000_0000; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_ready0", req0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
      check_eq("rr_ready1", req1_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
      tick();
      wait_rsp(1'b0, 20, cyc);
      check_eq("rr_latency", cyc, 4);
      check_eq("rr_id", rsp_id, (k % 2 == 1) ? 1'b1 : 1'b0);
      check_eq("rr_sum", rsp_sum, (k % 2 == 1) ? 32'h0000_0001 : 32'h2345_6789);
      check_eq("rr_cout", rsp_cout, (k % 2 == 1) ? 1'b1 : 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure held in DONE, then a pending request accepted right after.
    do_reset();
    rsp_ready = 1'b0;
    req0_a = 32'h0000_0010; req0_b = 32'h0000_0020; req0_cin = 1'b0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    wait_rsp(1'b0, 20, cyc);
    check_eq("bp_latency", cyc, 4);
    req1_a = 32'h0000_0005; req1_b = 32'h0000_0006; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid", rsp_valid, 1'b1);
      check_eq("bp_sum", rsp_sum, 32'h0000_0030);
      check_eq("bp_ready0", req0_ready, 1'b0);
      check_eq("bp_ready1", req1_ready, 1'b0);
      check_eq("bp_busy", busy, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_rel_valid", rsp_valid, 1'b0);
    check_eq("bp_rel_busy", busy, 1'b0);
    check_eq("bp_rel_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_eq("bp_acc_busy", busy, 1'b1);
    wait_rsp(1'b0, 20, cyc);
    check_eq("bp2_sum", rsp_sum, 32'h0000_000B);
    check_eq("bp2_id", rsp_id, 1'b1);
    tick();

    // Reset pulled two cycles into ADD.
    do_reset();
    req0_a = 32'h0101_0101; req0_b = 32'h0202_0202; req0_cin = 1'b0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", rsp_valid, 1'b0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_sum", rsp_sum, 32'h0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("mr_tie_ready0", req0_ready, 1'b1);
    check_eq("mr_tie_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single requester (req1 only).
    do_reset();
    req1_a = 32'h0000_00FF; req1_b = 32'h0000_0001; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    check_eq("sr_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    wait_rsp(1'b0, 20, cyc);
    check_eq("sr_sum", rsp_sum, 32'h0000_0100);
    check_eq("sr_id", rsp_id, 1'b1);
    check_eq("sr_cout", rsp_cout, 1'b0);

    // WORDS=1 instance.
    do_reset();
    w1_req0_a = 8'h7F; w1_req0_b = 8'h01; w1_req0_valid = 1'b1;
    #1;
    check_eq("w1_ready0", w1_req0_ready, 1'b1);
    tick();
    w1_req0_valid = 1'b0;
    wait_rsp(1'b1, 10, cyc);
    check_eq("w1_latency", cyc, 1);
    check_eq("w1_sum", w1_rsp_sum, 8'h80);
    check_eq("w1_cout", w1_rsp_cout, 1'b0);
`ifdef ADDER_SHARE_OVF_EN
    check_eq("w1_ovf", w1_rsp_ovf, 1'b1);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
